// File: rtl/fifo_stream_reader_if.sv
// Signal bundle between the stream reader, the FIFO read port it drains and the downstream byte-stream consumer.
// The master side is the reader; the slave side is the FIFO plus the consumer.
interface fifo_stream_reader_if #(
    parameter int Width = 9
);
    logic             FifoRead;
    logic [Width-1:0] FifoDout;
    logic             FifoValid;
    logic             FifoEmpty;
    logic [Width-2:0] OutData;
    logic             OutLast;
    logic             OutValid;
    logic             OutReady;

    modport master (
        output FifoRead,
        input  FifoDout,
        input  FifoValid,
        input  FifoEmpty,
        output OutData,
        output OutLast,
        output OutValid,
        input  OutReady
    );

    modport slave (
        input  FifoRead,
        output FifoDout,
        output FifoValid,
        output FifoEmpty,
        input  OutData,
        input  OutLast,
        input  OutValid,
        output OutReady
    );
endinterface

// File: rtl/fifo_stream_reader.sv
// Read engine for a standard-mode block RAM FIFO: pops words with one-cycle read latency into a 2-entry skid
// buffer and offers them as a ready/valid stream with end-of-packet, a packet counter and an overrun flag.
module fifo_stream_reader #(
    parameter int Width         = 9,
    parameter int PktCountWidth = 16
) (
    input  logic                     Clk,
    input  logic                     ResetN,
    input  logic                     Enable,
    input  logic                     Flush,
    fifo_stream_reader_if.master     bus,
    output logic [PktCountWidth-1:0] PktCount,
    output logic                     Busy,
    output logic                     Overrun
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        FLUSH = 2'd3
    } state_t;

    state_t                   state_q,     state_d;
    logic [Width-1:0]         entry_q [2];
    logic [Width-1:0]         entry_d [2];
    logic [1:0]               occ_q,       occ_d;
    logic                     in_flight_q, in_flight_d;
    logic [PktCountWidth-1:0] pkt_count_q, pkt_count_d;
    logic                     overrun_q,   overrun_d;

    logic       pop;
    logic       fifo_read;
    logic [2:0] credit;
    logic [1:0] occ_after_pop;

    // Credit counts words already buffered or on their way, so a new read never lands in a full buffer.
    always_comb begin
        pop           = (occ_q != 2'd0) && bus.OutReady;
        credit        = {1'b0, occ_q} + {2'b00, in_flight_q} - {2'b00, pop};
        occ_after_pop = occ_q - {1'b0, pop};
        fifo_read     = (state_q == RUN) && !bus.FifoEmpty && !Flush && (credit < 3'd2);
    end

    always_comb begin
        entry_d     = entry_q;
        occ_d       = occ_after_pop;
        overrun_d   = overrun_q;
        in_flight_d = fifo_read;
        pkt_count_d = pkt_count_q + PktCountWidth'(pop & entry_q[0][Width-1]);

        if (pop) begin
            entry_d[0] = entry_q[1];
        end

        if (Flush) begin
            occ_d = 2'd0;
        end else if (bus.FifoValid && (state_q != FLUSH)) begin
            if (!in_flight_q) begin
                overrun_d = 1'b1;
            end
            // With no room even after this cycle's pop the arriving word is lost.
            if (occ_after_pop == 2'd2) begin
                overrun_d = 1'b1;
            end else begin
                entry_d[occ_after_pop[0]] = bus.FifoDout;
                occ_d                     = occ_after_pop + 2'd1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (Flush) begin
            state_d = FLUSH;
        end else begin
            case (state_q)
                IDLE: begin
                    if (Enable) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (!Enable) begin
                        state_d = (in_flight_q || (occ_q != 2'd0)) ? DRAIN : IDLE;
                    end
                end
                DRAIN: begin
                    if (Enable) begin
                        state_d = RUN;
                    end else if ((occ_q == 2'd0) && !in_flight_q) begin
                        state_d = IDLE;
                    end
                end
                FLUSH: begin
                    if (!in_flight_q) begin
                        state_d = Enable ? RUN : IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state_q     <= IDLE;
            entry_q[0]  <= '0;
            entry_q[1]  <= '0;
            occ_q       <= 2'd0;
            in_flight_q <= 1'b0;
            pkt_count_q <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            entry_q[0]  <= entry_d[0];
            entry_q[1]  <= entry_d[1];
            occ_q       <= occ_d;
            in_flight_q <= in_flight_d;
            pkt_count_q <= pkt_count_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.FifoRead = fifo_read;
    assign bus.OutValid = (occ_q != 2'd0);
    assign bus.OutData  = entry_q[0][Width-2:0];
    assign bus.OutLast  = entry_q[0][Width-1];
    assign PktCount     = pkt_count_q;
    assign Busy         = (occ_q != 2'd0) || in_flight_q;
    assign Overrun      = overrun_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: a queue-based FIFO model feeds the reader, a scoreboard queue holds the words the
// stream must deliver, and an independent monitor compares every beat and the status outputs each cycle.
module tb_fifo_stream_reader;
    localparam int W   = 9;
    localparam int PCW = 8;

    logic           clk    = 1'b0;
    logic           rst_n  = 1'b0;
    logic           enable = 1'b0;
    logic           flush  = 1'b0;
    logic [PCW-1:0] pkt_count;
    logic           busy;
    logic           overrun;

    fifo_stream_reader_if #(.Width(W)) bus ();

    fifo_stream_reader #(.Width(W), .PktCountWidth(PCW)) dut (
        .Clk      (clk),
        .ResetN   (rst_n),
        .Enable   (enable),
        .Flush    (flush),
        .bus      (bus),
        .PktCount (pkt_count),
        .Busy     (busy),
        .Overrun  (overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] src_q[$];
    logic [W-1:0] exp_q[$];
    logic [W-1:0] pend_word = '0;
    bit           pend_valid = 1'b0;
    bit           delivered_now = 1'b0;
    bit           flush_prev = 1'b0;
    bit           inject_prev = 1'b0;
    bit           overrun_exp = 1'b0;
    bit           prev_read = 1'b0;
    int           pkt_model = 0;
    int           beat_cnt = 0;
    int           read_cnt = 0;
    int           cyc_n = 0;
    int           first_read_cyc = -1;
    int           model_occ;
    int           beat_cyc_q[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc_n <= cyc_n + 1;

    // FIFO read port model: a read seen this cycle returns its word next cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            pend_valid = 1'b0;
        end else if (bus.FifoRead && src_q.size() != 0) begin
            read_cnt++;
            if (first_read_cyc < 0) first_read_cyc = cyc_n;
            pend_word  = src_q.pop_front();
            pend_valid = 1'b1;
        end else begin
            pend_valid = 1'b0;
        end
    end

    // Monitor: beat-by-beat scoreboard plus status checks every cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_read = 1'b0;
            pkt_model = 0;
        end else begin
            model_occ = exp_q.size() - int'(delivered_now);
            chk("out_valid", int'(bus.OutValid), int'(model_occ != 0));
            chk("busy", int'(busy), int'((model_occ != 0) || prev_read));
            chk("overrun", int'(overrun), int'(overrun_exp));
            chk("pkt_count", int'(pkt_count), pkt_model % (1 << PCW));
            chk("read_rule", int'(bus.FifoRead && (bus.FifoEmpty || flush)), 0);
            if (bus.OutValid && bus.OutReady && exp_q.size() != 0) begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                chk("beat", int'({bus.OutLast, bus.OutData}), int'(e));
                beat_cnt++;
                beat_cyc_q.push_back(cyc_n);
                if (e[W-1]) pkt_model++;
                $display("beat %0d data=%02h last=%0b pkts=%0d", beat_cnt, bus.OutData, bus.OutLast, pkt_model);
            end
            prev_read = bus.FifoRead;
        end
    end

    task automatic cyc(input bit en, input bit fl, input bit rdy, input bit inj = 1'b0);
        @(posedge clk);
        #1;
        if (flush_prev) exp_q.delete();
        if (inject_prev) overrun_exp = 1'b1;
        enable       = en;
        flush        = fl;
        bus.OutReady = rdy;
        if (inj) begin
            bus.FifoValid = 1'b1;
            bus.FifoDout  = W'($urandom);
            delivered_now = 1'b0;
        end else begin
            bus.FifoValid = pend_valid;
            bus.FifoDout  = pend_valid ? pend_word : W'($urandom);
            delivered_now = pend_valid && !fl;
            if (delivered_now) exp_q.push_back(pend_word);
        end
        bus.FifoEmpty = (src_q.size() == 0);
        flush_prev    = fl;
        inject_prev   = inj;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n         = 1'b0;
        enable        = 1'b0;
        flush         = 1'b0;
        bus.OutReady  = 1'b0;
        bus.FifoValid = 1'b0;
        bus.FifoDout  = '0;
        bus.FifoEmpty = 1'b1;
        #1;
        chk("rst_fifo_read", int'(bus.FifoRead), 0);
        chk("rst_out_valid", int'(bus.OutValid), 0);
        chk("rst_out_data", int'(bus.OutData), 0);
        chk("rst_out_last", int'(bus.OutLast), 0);
        chk("rst_pkt_count", int'(pkt_count), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_overrun", int'(overrun), 0);
        src_q.delete();
        exp_q.delete();
        beat_cyc_q.delete();
        flush_prev     = 1'b0;
        inject_prev    = 1'b0;
        overrun_exp    = 1'b0;
        delivered_now  = 1'b0;
        read_cnt       = 0;
        beat_cnt       = 0;
        first_read_cyc = -1;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int b0, b1, b2;
        bit seen;
        bus.OutReady  = 1'b0;
        bus.FifoValid = 1'b0;
        bus.FifoDout  = '0;
        bus.FifoEmpty = 1'b1;

        // Three-beat packet at full rate: latency and throughput.
        do_reset();
        src_q = '{9'h041, 9'h042, 9'h1C3};
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 1'b1);
        @(negedge clk);
        chk("t1_beats", beat_cnt, 3);
        b0 = (beat_cyc_q.size() > 0) ? beat_cyc_q[0] : -100;
        b1 = (beat_cyc_q.size() > 1) ? beat_cyc_q[1] : -100;
        b2 = (beat_cyc_q.size() > 2) ? beat_cyc_q[2] : -100;
        chk("t1_latency", b0 - first_read_cyc, 2);
        chk("t1_gap1", b1 - b0, 1);
        chk("t1_gap2", b2 - b1, 1);
        chk("t1_pkt", int'(pkt_count), 1);

        // Back-pressure: buffer fills at two words and reads stop.
        do_reset();
        src_q = '{9'h041, 9'h042, 9'h1C3};
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("t2_reads_stalled", read_cnt, 2);
        chk("t2_fifo_read_held", int'(bus.FifoRead), 0);
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 1'b1);
        @(negedge clk);
        chk("t2_reads_total", read_cnt, 3);
        chk("t2_beats", beat_cnt, 3);
        chk("t2_pkt", int'(pkt_count), 1);

        // 300 single-beat packets into an 8-bit counter.
        do_reset();
        for (int i = 0; i < 300; i++) src_q.push_back({1'b1, 8'($urandom)});
        for (int i = 0; i < 3000 && beat_cnt < 300; i++) cyc(1'b1, 1'b0, $urandom_range(0, 3) != 0);
        cyc(1'b1, 1'b0, 1'b1);
        @(negedge clk);
        chk("t3_beats", beat_cnt, 300);
        chk("t3_pkt_wrap", int'(pkt_count), 44);

        // Enable dropped right after the first read: drain then idle.
        do_reset();
        for (int i = 0; i < 5; i++) src_q.push_back({1'b0, 8'($urandom)});
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            cyc(1'b1, 1'b0, 1'b1);
            @(negedge clk);
            seen = bus.FifoRead;
        end
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("t4_reads", read_cnt, 2);
        chk("t4_beats", beat_cnt, 2);
        chk("t4_left_in_fifo", src_q.size(), 3);
        chk("t4_busy", int'(busy), 0);
        chk("t4_idle_no_read", int'(bus.FifoRead), 0);

        // Flush with a buffered word and a read in flight; pop in the flush cycle still counts.
        do_reset();
        for (int i = 0; i < 6; i++) src_q.push_back({1'b1, 8'(8'h10 + i)});
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("t5_valid_after_flush", int'(bus.OutValid), 0);
        for (int i = 0; i < 12; i++) cyc(1'b1, 1'b0, 1'b1);
        @(negedge clk);
        chk("t5_beats", beat_cnt, 5);
        chk("t5_pkt", int'(pkt_count), 5);
        chk("t5_overrun", int'(overrun), 0);

        // Unsolicited word into a full buffer: sticky overrun until reset.
        do_reset();
        for (int i = 0; i < 4; i++) src_q.push_back({1'b0, 8'($urandom)});
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("t6_overrun_set", int'(overrun), 1);
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b1);
        @(negedge clk);
        chk("t6_overrun_sticky", int'(overrun), 1);
        chk("t6_beats", beat_cnt, 4);

        // Random traffic with random enable, flush and back-pressure.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (src_q.size() < 4 && $urandom_range(0, 2) == 0) begin
                for (int k = 0; k < int'($urandom_range(1, 5)); k++) src_q.push_back(W'($urandom));
            end
            cyc($urandom_range(0, 9) != 0, ($urandom_range(0, 39) == 0) && !flush_prev,
                $urandom_range(0, 2) != 0);
        end
        for (int i = 0; i < 300 && (src_q.size() != 0 || exp_q.size() != 0 || busy); i++)
            cyc(1'b1, 1'b0, 1'b1);
        @(negedge clk);
        chk("rand_drained", src_q.size() + exp_q.size(), 0);
        chk("rand_overrun", int'(overrun), 0);

        do_reset();
        cyc(1'b0, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
